reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter n, default 32: data width of every register and of all data ports.
REQ-002 Parameter DEPTH, default 32: number of architectural registers; address width is log2(DEPTH), 5 at default.
REQ-003 clk  input  1: the single clock; all state updates on rising edge.
REQ-004 rst  input  1: reset, asynchronous, active-high.
REQ-005 rs1_addr, rs2_addr  input  5: read-port addresses.
REQ-006 rs1_data, rs2_data  output  n: read-port data, combinational from stored contents.
REQ-007 reg_write  input  1: write enable.
REQ-008 rd_addr  input  5: write address.
REQ-009 rd_data  input  n: write data.
REQ-010 dump_start  input  1: one-cycle request to stream out all registers.
REQ-011 dump_valid  output  1: dump_data/dump_idx hold a valid beat.
REQ-012 dump_ready  input  1: consumer accepts the current beat.
REQ-013 dump_data  output  n: registered dump beat data.
REQ-014 dump_idx  output  5: register index of the current beat.
REQ-015 dump_done  output  1: one-cycle pulse after the last beat is accepted.

Function
REQ-016 On a rising edge with reg_write=1 and rd_addr!=0, register[rd_addr] SHALL take rd_data; it SHALL otherwise hold its value.
REQ-017 Register 0 SHALL always read 0; writes to address 0 SHALL be discarded.
REQ-018 A read of the address being written in the same cycle SHALL return the old value; the new value SHALL be visible the cycle after the edge (no bypass).
REQ-019 The dump FSM SHALL have states IDLE and STREAM.
REQ-020 In IDLE, dump_start=1 SHALL move to STREAM at the next edge, with dump_idx=0, dump_data=register[0] and dump_valid=1 (latency: 1 cycle).
REQ-021 In STREAM, dump_valid=1 and dump_ready=0 SHALL hold dump_idx and dump_data unchanged, including when that register is written meanwhile.
REQ-022 In STREAM, dump_valid=1 and dump_ready=1 with dump_idx<DEPTH-1 SHALL advance dump_idx by 1 and capture that register's post-edge contents into dump_data (the current cycle's write is included).
REQ-023 In STREAM, acceptance at dump_idx=DEPTH-1 SHALL return the FSM to IDLE, clear dump_valid and pulse dump_done for exactly one cycle.
REQ-024 dump_start SHALL be ignored in STREAM and in the dump_done cycle; no queuing.
REQ-025 Read and write ports SHALL operate unaffected during a dump.

Reset
REQ-026 rst=1 SHALL immediately clear all registers to 0, force IDLE, and drive dump_valid=0, dump_done=0, dump_data=0 and dump_idx=0, regardless of clk.
REQ-027 Reset asserted mid-dump SHALL abort the dump without a dump_done pulse; a new dump SHALL require a fresh dump_start after release.

Structure
REQ-028 A shared package SHALL hold the DEPTH and n defaults, the address-width constant and the dump-state encoding (IDLE=0, STREAM=1).
REQ-029 The dump FSM and its index counter SHALL be one sub-module, reg_dump_fsm; the storage array and read/write logic SHALL sit in reg_file.

Verification
REQ-030 Write 0xDEADBEEF to x5, then read x5 on rs1 and rs2 -> both ports return 0xDEADBEEF on the next cycle.
REQ-031 Write 0x12345678 to x0, then read x0 -> 0x00000000.
REQ-032 Write x7=0xA while rs1_addr=7 in the same cycle -> rs1_data shows the old value that cycle and 0xA the next cycle.
REQ-033 Load x1..x31 with values 0x100+i, pulse dump_start, hold dump_ready=1 -> 32 beats with idx 0..31, data 0,0x101..0x11F, then dump_done high for one cycle.
REQ-034 Stall dump_ready=0 at idx 3 for 4 cycles while writing x3=0xFF -> idx 3 data stays 0x103; the write is visible in the register file afterwards.
REQ-035 Assert rst at idx 10 -> dump_valid=0 immediately, no dump_done, and all registers read 0.

Source files
------------

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared sizes and dump-state encoding for the register file
package reg_file_pkg;
    localparam int N_DEF     = 32;
    localparam int DEPTH_DEF = 32;
    localparam int AW_DEF    = $clog2(DEPTH_DEF);
    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } dump_state_e;
endpackage

// File: rtl/reg_file_dump_fsm.sv
// reg_dump_fsm: streams register contents out one beat at a time under valid/ready
// Ports: clk, rst (async, active-high); dump_start/dump_ready in; dump_valid/dump_data/
// dump_idx/dump_done out; fetch_idx names the register loaded next, fetch_data is its post-edge value.
module reg_dump_fsm
    import reg_file_pkg::*;
#(
    parameter int n     = N_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dump_start,
    input  logic          dump_ready,
    input  logic [n-1:0]  fetch_data,
    output logic [AW-1:0] fetch_idx,
    output logic          dump_valid,
    output logic [n-1:0]  dump_data,
    output logic [AW-1:0] dump_idx,
    output logic          dump_done
);
    dump_state_e   state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [n-1:0]  data_q, data_d;
    logic          done_q, done_d;
    logic          last;

    assign last       = idx_q == AW'(DEPTH - 1);
    assign fetch_idx  = (state_q == STREAM) ? idx_q + 1'b1 : '0;
    assign dump_valid = state_q == STREAM;
    assign dump_data  = data_q;
    assign dump_idx   = idx_q;
    assign dump_done  = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    // A start arriving in the done cycle is dropped, not queued.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (dump_start && !done_q) begin
                state_d = STREAM;
                idx_d   = '0;
                data_d  = fetch_data;
            end
        end else if (dump_ready) begin
            state_d = last ? IDLE : STREAM;
            done_d  = last;
            idx_d   = last ? idx_q : fetch_idx;
            data_d  = last ? data_q : fetch_data;
        end
    end
endmodule

// File: rtl/reg_file.sv
// reg_file: register file with two combinational read ports, one write port and a streaming dump
// Ports: clk, rst (async, active-high); rs1/rs2 read ports; reg_write/rd_addr/rd_data write port;
// dump_start/dump_ready in, dump_valid/dump_data/dump_idx/dump_done out.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int n     = N_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rs1_addr,
    input  logic [AW-1:0] rs2_addr,
    output logic [n-1:0]  rs1_data,
    output logic [n-1:0]  rs2_data,
    input  logic          reg_write,
    input  logic [AW-1:0] rd_addr,
    input  logic [n-1:0]  rd_data,
    input  logic          dump_start,
    output logic          dump_valid,
    input  logic          dump_ready,
    output logic [n-1:0]  dump_data,
    output logic [AW-1:0] dump_idx,
    output logic          dump_done
);
    logic [n-1:0]  regs_q [DEPTH];
    logic          we;
    logic [AW-1:0] fetch_idx;
    logic [n-1:0]  fetch_data;

    assign we       = reg_write && rd_addr != '0;
    assign rs1_data = regs_q[rs1_addr];
    assign rs2_data = regs_q[rs2_addr];
    // The dump captures the value the register holds after this edge, so forward a same-cycle write.
    assign fetch_data = (we && rd_addr == fetch_idx) ? rd_data : regs_q[fetch_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else if (we) begin
            regs_q[rd_addr] <= rd_data;
        end
    end

    reg_dump_fsm #(.n(n), .DEPTH(DEPTH)) u_dump (
        .clk        (clk),
        .rst        (rst),
        .dump_start (dump_start),
        .dump_ready (dump_ready),
        .fetch_data (fetch_data),
        .fetch_idx  (fetch_idx),
        .dump_valid (dump_valid),
        .dump_data  (dump_data),
        .dump_idx   (dump_idx),
        .dump_done  (dump_done)
    );
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed self-checking bench for reg_file
module tb_reg_file;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rs1_addr = '0, rs2_addr = '0, rd_addr = '0;
    logic [31:0] rs1_data, rs2_data, rd_data = '0, dump_data;
    logic        reg_write = 1'b0, dump_start = 1'b0, dump_ready = 1'b0;
    logic        dump_valid, dump_done;
    logic [4:0]  dump_idx;
    int checks = 0;
    int failures = 0;

    reg_file dut (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .reg_write(reg_write), .rd_addr(rd_addr), .rd_data(rd_data),
        .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_data(dump_data), .dump_idx(dump_idx), .dump_done(dump_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    initial begin
        #1;
        chk("rst_valid", 32'(dump_valid), 0);
        chk("rst_done", 32'(dump_done), 0);
        chk("rst_data", dump_data, 0);
        chk("rst_idx", 32'(dump_idx), 0);
        chk("rst_rs1", rs1_data, 0);
        tick();
        rst = 1'b0;
        tick();

        reg_write = 1; rd_addr = 5; rd_data = 32'hDEADBEEF;
        tick();
        reg_write = 0; rs1_addr = 5; rs2_addr = 5;
        #1;
        chk("x5_rs1", rs1_data, 32'hDEADBEEF);
        chk("x5_rs2", rs2_data, 32'hDEADBEEF);

        reg_write = 1; rd_addr = 0; rd_data = 32'h12345678;
        tick();
        reg_write = 0; rs1_addr = 0;
        #1;
        chk("x0_zero", rs1_data, 0);

        rs1_addr = 7; reg_write = 1; rd_addr = 7; rd_data = 32'hA;
        #1;
        chk("x7_old", rs1_data, 0);
        tick();
        reg_write = 0;
        chk("x7_new", rs1_data, 32'hA);

        for (int i = 1; i < 32; i++) begin
            reg_write = 1; rd_addr = 5'(i); rd_data = 32'h100 + 32'(i);
            tick();
        end
        reg_write = 0;
        chk("idle_valid", 32'(dump_valid), 0);
        dump_start = 1; dump_ready = 1;
        tick();
        dump_start = 0;
        for (int b = 0; b < 32; b++) begin
            chk("beat_valid", 32'(dump_valid), 1);
            chk("beat_idx", 32'(dump_idx), 32'(b));
            chk("beat_data", dump_data, (b == 0) ? 32'h0 : 32'h100 + 32'(b));
            chk("beat_nodone", 32'(dump_done), 0);
            dump_start = (b == 5);
            tick();
        end
        dump_start = 0;
        chk("done_pulse", 32'(dump_done), 1);
        chk("done_valid", 32'(dump_valid), 0);
        dump_start = 1;
        tick();
        dump_start = 0;
        chk("done_once", 32'(dump_done), 0);
        chk("start_in_done_ignored", 32'(dump_valid), 0);

        dump_start = 1; dump_ready = 1;
        tick();
        dump_start = 0;
        tick(); tick(); tick();
        chk("stall_idx", 32'(dump_idx), 3);
        dump_ready = 0; reg_write = 1; rd_addr = 3; rd_data = 32'hFF;
        for (int c = 0; c < 4; c++) begin
            tick();
            reg_write = 0;
            chk("stall_hold_idx", 32'(dump_idx), 3);
            chk("stall_hold_data", dump_data, 32'h103);
        end
        rs1_addr = 3;
        #1;
        chk("x3_written", rs1_data, 32'hFF);
        dump_ready = 1;
        tick();
        chk("resume_idx", 32'(dump_idx), 4);
        chk("resume_data", dump_data, 32'h104);
        reg_write = 1; rd_addr = 5; rd_data = 32'h555;
        tick();
        reg_write = 0;
        chk("fwd_idx", 32'(dump_idx), 5);
        chk("fwd_data", dump_data, 32'h555);
        for (int c = 0; c < 5; c++) tick();
        chk("pre_rst_idx", 32'(dump_idx), 10);
        chk("pre_rst_data", dump_data, 32'h10A);

        rst = 1; rs1_addr = 3; rs2_addr = 31;
        #1;
        chk("arst_valid", 32'(dump_valid), 0);
        chk("arst_idx", 32'(dump_idx), 0);
        chk("arst_data", dump_data, 0);
        chk("arst_done", 32'(dump_done), 0);
        chk("arst_rs1", rs1_data, 0);
        chk("arst_rs2", rs2_data, 0);
        tick();
        rst = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("post_rst_nodone", 32'(dump_done), 0);
            chk("post_rst_idle", 32'(dump_valid), 0);
        end
        dump_start = 1;
        tick();
        dump_start = 0;
        chk("restart_valid", 32'(dump_valid), 1);
        chk("restart_idx", 32'(dump_idx), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
